// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared definitions for the writeback unit: bus widths, load funct3 codes, FSM states.
package ysyx_23060332_wbu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_LSU = 1'b1
  } wbu_state_e;

endpackage

// File: rtl/ysyx_23060332_load_ext.sv
// Combinational load alignment: shifts the word-aligned LSU data by the byte offset,
// then sign/zero extends according to funct3 and flags misaligned or unknown encodings.
module ysyx_23060332_load_ext
  import ysyx_23060332_wbu_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] ext_data,
  output logic              illegal
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    ext_data = '0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:  ext_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      F3_LBU: ext_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_LH: begin
        ext_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        illegal  = off[0];
      end
      F3_LHU: begin
        ext_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
        illegal  = off[0];
      end
      F3_LW: begin
        ext_data = rdata;
        illegal  = (off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Writeback unit: accepts EXU results, waits for LSU data on loads, and issues one
// registered register-file write per instruction while reporting the pending destination.
module ysyx_23060332_wbu
  import ysyx_23060332_wbu_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_result,
  input  logic              exu_is_load,
  input  logic [2:0]        exu_funct3,
  input  logic              lsu_rvalid,
  input  logic [DATA_W-1:0] lsu_rdata,
  input  logic              lsu_rerr,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              reg_wen,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_rd,
  output logic              retire,
  output logic              load_err
);

  wbu_state_e        state;
  logic [ADDR_W-1:0] ld_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_off;
  logic [DATA_W-1:0] ext_data;
  logic              ext_illegal;
  logic              waiting;

  ysyx_23060332_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .rdata    (lsu_rdata),
    .off      (ld_off),
    .funct3   (ld_funct3),
    .ext_data (ext_data),
    .illegal  (ext_illegal)
  );

  assign waiting    = (state == ST_WAIT_LSU);
  assign exu_ready  = (state == ST_IDLE) && !rst;
  // A load to x0 never writes, so it is not a hazard for the IDU.
  assign pend_valid = (waiting && (ld_rd != '0)) || reg_wen;
  assign pend_rd    = !pend_valid ? '0 : (waiting ? ld_rd : waddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ld_rd     <= '0;
      ld_funct3 <= '0;
      ld_off    <= '0;
      waddr     <= '0;
      wdata     <= '0;
      reg_wen   <= 1'b0;
      retire    <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      reg_wen  <= 1'b0;
      retire   <= 1'b0;
      load_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (exu_valid) begin
            if (exu_is_load) begin
              ld_rd     <= exu_rd;
              ld_funct3 <= exu_funct3;
              ld_off    <= exu_result[1:0];
              state     <= ST_WAIT_LSU;
            end else begin
              retire <= 1'b1;
              if (exu_rd != '0) begin
                reg_wen <= 1'b1;
                waddr   <= exu_rd;
                wdata   <= exu_result;
              end
            end
          end
        end
        ST_WAIT_LSU: begin
          if (lsu_rvalid) begin
            state  <= ST_IDLE;
            retire <= 1'b1;
            if (!ext_illegal && !lsu_rerr) begin
              if (ld_rd != '0) begin
                reg_wen <= 1'b1;
                waddr   <= ld_rd;
                wdata   <= ext_data;
              end
            end else begin
              load_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Self-checking bench for the writeback unit: directed scenarios followed by a
// randomized mix of ALU results, loads and stray LSU responses against a reference model.
module tb_ysyx_23060332_wbu;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_result;
  logic        exu_is_load;
  logic [2:0]  exu_funct3;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_rerr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        reg_wen;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        retire;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  // Model of the held write port contents.
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  ysyx_23060332_wbu dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_result  (exu_result),
    .exu_is_load (exu_is_load),
    .exu_funct3  (exu_funct3),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rdata   (lsu_rdata),
    .lsu_rerr    (lsu_rerr),
    .waddr       (waddr),
    .wdata       (wdata),
    .reg_wen     (reg_wen),
    .pend_valid  (pend_valid),
    .pend_rd     (pend_rd),
    .retire      (retire),
    .load_err    (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed byte/half from the word with plain arithmetic.
  function automatic void ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] rdata, output bit legal,
                                   output logic [31:0] val);
    longint unsigned word = rdata;
    int unsigned off = addr % 4;
    longint unsigned b = (word / (64'd1 << (8 * off))) % 256;
    longint unsigned h = (word / (64'd1 << (8 * off))) % 65536;
    legal = 1'b1;
    val   = 32'd0;
    case (f3)
      3'd0: val = (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd4: val = 32'(b);
      3'd1: begin legal = (off % 2 == 0); val = (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h); end
      3'd5: begin legal = (off % 2 == 0); val = 32'(h); end
      3'd2: begin legal = (off == 0); val = rdata; end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic check_port(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 32'(exp_waddr));
    chk({tag, ".wdata"}, wdata, exp_wdata);
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    exu_valid = 1'b1; exu_is_load = 1'b0; exu_rd = rd; exu_result = res;
    exu_funct3 = 3'($urandom_range(7));
    @(posedge clk); #1;
    exu_valid = 1'b0;
    if (rd != 0) begin exp_waddr = rd; exp_wdata = res; end
    chk("alu.reg_wen", 32'(reg_wen), 32'(rd != 0));
    chk("alu.retire", 32'(retire), 32'd1);
    chk("alu.load_err", 32'(load_err), 32'd0);
    chk("alu.exu_ready", 32'(exu_ready), 32'd1);
    chk("alu.pend_valid", 32'(pend_valid), 32'(rd != 0));
    if (rd != 0) chk("alu.pend_rd", 32'(pend_rd), 32'(rd));
    check_port("alu");
    $display("ALU rd=%0d result=%h reg_wen=%0b", rd, res, reg_wen);
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] rdata, input logic err, input int delay);
    bit legal;
    logic [31:0] val;
    bit good;
    ref_load(f3, addr, rdata, legal, val);
    good = legal && !err;
    exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd = rd; exu_result = addr; exu_funct3 = f3;
    @(posedge clk); #1;
    exu_valid = 1'b0;
    chk("ld_accept.reg_wen", 32'(reg_wen), 32'd0);
    chk("ld_accept.retire", 32'(retire), 32'd0);
    for (int i = 0; i < delay; i++) begin
      chk("ld_wait.exu_ready", 32'(exu_ready), 32'd0);
      chk("ld_wait.pend_valid", 32'(pend_valid), 32'(rd != 0));
      if (rd != 0) chk("ld_wait.pend_rd", 32'(pend_rd), 32'(rd));
      if (i == delay - 1) begin
        lsu_rvalid = 1'b1; lsu_rdata = rdata; lsu_rerr = err;
      end
      @(posedge clk); #1;
    end
    lsu_rvalid = 1'b0; lsu_rerr = 1'b0; lsu_rdata = $urandom;
    if (good && rd != 0) begin exp_waddr = rd; exp_wdata = val; end
    chk("ld_done.reg_wen", 32'(reg_wen), 32'(good && rd != 0));
    chk("ld_done.retire", 32'(retire), 32'd1);
    chk("ld_done.load_err", 32'(load_err), 32'(!good));
    chk("ld_done.exu_ready", 32'(exu_ready), 32'd1);
    chk("ld_done.pend_valid", 32'(pend_valid), 32'(good && rd != 0));
    check_port("ld_done");
    $display("LOAD rd=%0d f3=%0d addr=%h rdata=%h err=%0b -> reg_wen=%0b wdata=%h load_err=%0b",
             rd, f3, addr, rdata, err, reg_wen, wdata, load_err);
  endtask

  task automatic stray();
    lsu_rvalid = 1'b1; lsu_rdata = $urandom; lsu_rerr = 1'($urandom_range(1));
    @(posedge clk); #1;
    lsu_rvalid = 1'b0; lsu_rerr = 1'b0;
    chk("stray.reg_wen", 32'(reg_wen), 32'd0);
    chk("stray.retire", 32'(retire), 32'd0);
    chk("stray.load_err", 32'(load_err), 32'd0);
    chk("stray.exu_ready", 32'(exu_ready), 32'd1);
    check_port("stray");
    $display("STRAY lsu_rvalid in IDLE reg_wen=%0b retire=%0b", reg_wen, retire);
  endtask

  initial begin
    rst = 1'b1; exu_valid = 1'b0; exu_rd = '0; exu_result = '0; exu_is_load = 1'b0;
    exu_funct3 = '0; lsu_rvalid = 1'b0; lsu_rdata = '0; lsu_rerr = 1'b0;
    exp_waddr = '0; exp_wdata = '0;
    #1;
    chk("rst.exu_ready", 32'(exu_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst.reg_wen", 32'(reg_wen), 32'd0);
    chk("rst.retire", 32'(retire), 32'd0);
    chk("rst.load_err", 32'(load_err), 32'd0);
    chk("rst.pend_valid", 32'(pend_valid), 32'd0);
    chk("rst.pend_rd", 32'(pend_rd), 32'd0);
    check_port("rst");
    rst = 1'b0;
    #1;
    chk("rst_release.exu_ready", 32'(exu_ready), 32'd1);
    $display("RESET done");

    // Directed scenarios
    alu(5'd5, 32'h1234_5678);
    alu(5'd0, 32'hFFFF_FFFF);
    alu(5'd6, 32'hA5A5_0001);
    load(5'd7, 3'b000, 32'h0000_1003, 32'h80AA_BBCC, 1'b0, 3);
    load(5'd8, 3'b101, 32'h0000_2002, 32'hBEEF_0000, 1'b0, 1);
    load(5'd9, 3'b010, 32'h0000_3001, 32'h1111_2222, 1'b0, 2);
    load(5'd10, 3'b010, 32'h0000_4000, 32'h3333_4444, 1'b1, 1);
    load(5'd11, 3'b011, 32'h0000_5000, 32'h5555_6666, 1'b0, 1);
    load(5'd0, 3'b010, 32'h0000_6000, 32'h7777_8888, 1'b0, 2);
    stray();

    // Reset in the middle of a load
    alu(5'd9, 32'hCAFE_F00D);
    exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd = 5'd12; exu_funct3 = 3'b010; exu_result = '0;
    @(posedge clk); #1;
    exu_valid = 1'b0;
    chk("mid.pend_valid", 32'(pend_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    exp_waddr = '0; exp_wdata = '0;
    chk("mid_rst.exu_ready", 32'(exu_ready), 32'd0);
    chk("mid_rst.pend_valid", 32'(pend_valid), 32'd0);
    chk("mid_rst.reg_wen", 32'(reg_wen), 32'd0);
    check_port("mid_rst");
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    lsu_rvalid = 1'b1; lsu_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    lsu_rvalid = 1'b0;
    chk("post_rst.reg_wen", 32'(reg_wen), 32'd0);
    chk("post_rst.retire", 32'(retire), 32'd0);
    chk("post_rst.load_err", 32'(load_err), 32'd0);
    check_port("post_rst");
    $display("RESET mid-load handled reg_wen=%0b", reg_wen);
    alu(5'd14, 32'h0BAD_BEEF);

    // Randomized mix
    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(9);
      logic [4:0] rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      if (kind < 4) begin
        alu(rd, $urandom);
      end else if (kind < 9) begin
        load(rd, 3'($urandom), $urandom, $urandom, ($urandom_range(7) == 0),
             int'($urandom_range(1, 4)));
      end else begin
        stray();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
